// File: rtl/oc8051_xram_arbiter.sv
// Round-robin arbiter sharing the XRAM/MMIO port among NREQ masters, with a page-table permission check per access.
// Optional ACCESS watchdog is enabled by defining OC8051_ARB_TIMEOUT_EN.
module oc8051_xram_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_stb,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [16*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_err,
    output logic [7:0]           rsp_data,
    output logic                 busy,
    output logic [15:0]          xram_addr,
    output logic                 xram_wr,
    output logic [7:0]           xram_data_out,
    output logic [2:0]           accesser,
    output logic                 xram_stb,
    input  logic                 pt_wr_en,
    input  logic                 pt_rd_en,
    output logic                 mem_stb,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_data_in
);

    if (NREQ < 1 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_err
        $error("oc8051_xram_arbiter: NREQ must be 1..8 and TIMEOUT 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ACCESS, S_RESP} state_e;

    state_e          state_q;
    logic [2:0]      ptr_q;
    logic [2:0]      idx_q;
    logic            wr_q;
    logic [15:0]     addr_q;
    logic [7:0]      data_q;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] err_q;
    logic [7:0]      rsp_q;
    logic            xstb_q;
    logic            mstb_q;
`ifdef OC8051_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]      tmo_q;
`endif

    logic            gnt_vld;
    logic [2:0]      gnt_idx;
    logic [2:0]      ptr_d;
    logic            sel_wr;
    logic [15:0]     sel_addr;
    logic [7:0]      sel_data;
    logic [NREQ-1:0] idx_oh;
    logic [7:0]      req_pad;
    logic            permit;

    assign req_pad = 8'(req_stb);
    assign permit  = wr_q ? pt_wr_en : pt_rd_en;

    // Round-robin search starting at ptr_q, wrapping at NREQ.
    always_comb begin : p_grant
        logic [3:0] pos;
        pos     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = 4'(ptr_q) + 4'(i);
            if (pos >= 4'(NREQ)) pos = pos - 4'(NREQ);
            if (!gnt_vld && req_pad[pos[2:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = pos[2:0];
            end
        end
        ptr_d = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end

    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        idx_oh   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (3'(k) == gnt_idx) begin
                sel_wr   = req_wr[k];
                sel_addr = req_addr[16*k +: 16];
                sel_data = req_data[8*k +: 8];
            end
            idx_oh[k] = (3'(k) == idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rsp_q   <= '0;
            xstb_q  <= 1'b0;
            mstb_q  <= 1'b0;
`ifdef OC8051_ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            // NOTE: ack/err are single-cycle pulses, so they default low every cycle and only RESP entry raises them.
            ack_q <= '0;
            err_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        state_q <= S_CHECK;
                        idx_q   <= gnt_idx;
                        wr_q    <= sel_wr;
                        addr_q  <= sel_addr;
                        data_q  <= sel_data;
                        ptr_q   <= ptr_d;
                        xstb_q  <= 1'b1;
                    end
                end
                S_CHECK: begin
                    xstb_q <= 1'b0;
                    if (permit) begin
                        state_q <= S_ACCESS;
                        mstb_q  <= 1'b1;
`ifdef OC8051_ARB_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end else begin
                        state_q <= S_RESP;
                        ack_q   <= idx_oh;
                        err_q   <= idx_oh;
                        if (!wr_q) rsp_q <= '0;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        state_q <= S_RESP;
                        mstb_q  <= 1'b0;
                        ack_q   <= idx_oh;
                        if (!wr_q) rsp_q <= mem_data_in;
`ifdef OC8051_ARB_TIMEOUT_EN
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_RESP;
                        mstb_q  <= 1'b0;
                        ack_q   <= idx_oh;
                        err_q   <= idx_oh;
                        if (!wr_q) rsp_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
`endif
                    end
                end
                S_RESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ack       = ack_q;
    assign req_err       = err_q;
    assign rsp_data      = rsp_q;
    assign busy          = (state_q != S_IDLE);
    assign xram_addr     = addr_q;
    assign xram_wr       = wr_q;
    assign xram_data_out = data_q;
    assign accesser      = idx_q;
    assign xram_stb      = xstb_q;
    assign mem_stb       = mstb_q;

endmodule

// File: tb/tb_oc8051_xram_arbiter.sv
// Directed bench for oc8051_xram_arbiter: vector table of single transactions plus
// round-robin, early-drop, reset-abort and timeout sequences (OC8051_ARB_TIMEOUT_EN aware).
module tb_oc8051_xram_arbiter;

    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_stb, req_wr, req_ack, req_err;
    logic [16*NREQ-1:0]  req_addr;
    logic [8*NREQ-1:0]   req_data;
    logic [7:0]          rsp_data, xram_data_out, mem_data_in;
    logic                busy, xram_wr, xram_stb, mem_stb, mem_ack;
    logic                pt_wr_en, pt_rd_en;
    logic [15:0]         xram_addr;
    logic [2:0]          accesser;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_ctr  = 0;
    int   stb_cnt;
    int   mem_delay;
    bit   mem_never;
    logic [7:0] mem_rdata;
    int   addr_glitch = 0;
    logic prev_busy = 1'b0;
    logic [15:0] prev_addr = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    oc8051_xram_arbiter #(.NREQ(NREQ), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_stb(req_stb), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
        .req_ack(req_ack), .req_err(req_err), .rsp_data(rsp_data), .busy(busy),
        .xram_addr(xram_addr), .xram_wr(xram_wr), .xram_data_out(xram_data_out),
        .accesser(accesser), .xram_stb(xram_stb),
        .pt_wr_en(pt_wr_en), .pt_rd_en(pt_rd_en),
        .mem_stb(mem_stb), .mem_ack(mem_ack), .mem_data_in(mem_data_in)
    );

    // Memory model: acks in the (mem_delay+1)-th cycle of mem_stb, combinationally.
    always @(posedge clk or negedge rst) begin
        if (!rst) stb_cnt <= 0;
        else if (mem_stb && !mem_ack) stb_cnt <= stb_cnt + 1;
        else stb_cnt <= 0;
    end
    assign mem_ack     = mem_stb && !mem_never && (stb_cnt == mem_delay);
    assign mem_data_in = mem_rdata;

    // Latched address must not move while a transfer is in flight.
    always @(negedge clk) begin
        if (rst && busy && prev_busy && xram_addr !== prev_addr) addr_glitch++;
        prev_busy = busy;
        prev_addr = xram_addr;
    end

    typedef struct {
        int         idx;
        logic       wr;
        logic [15:0] addr;
        logic [7:0] data;
        logic       rd_en;
        logic       wr_en;
        int         delay;
        logic [7:0] mdata;
        logic       err;
        int         ack_cyc;
        int         mstb_first;
        int         mstb_cnt;
        logic [7:0] rsp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output int n, output logic [3:0] ackv,
                            output logic [3:0] errv);
        n = 0; ackv = '0; errv = '0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                n = k; ackv = req_ack; errv = req_err;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_stb = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int xfirst = 0, mfirst = 0, mcnt = 0, ack_cyc = 0, bad = 0;
        logic [3:0] ackv = '0, errv = '0, oh;
        logic [7:0] rsp = '0;
        oh = 4'b0001 << v.idx;
        pt_rd_en = v.rd_en; pt_wr_en = v.wr_en;
        mem_delay = v.delay; mem_rdata = v.mdata; mem_never = 1'b0;
        req_wr[v.idx] = v.wr;
        req_addr[16*v.idx +: 16] = v.addr;
        req_data[8*v.idx +: 8] = v.data;
        req_stb[v.idx] = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (xram_stb && xfirst == 0) xfirst = cyc;
            if (mem_stb) begin
                mcnt++;
                if (mfirst == 0) mfirst = cyc;
            end
            if (busy && (xram_addr !== v.addr || accesser !== 3'(v.idx) || xram_wr !== v.wr ||
                         (v.wr && xram_data_out !== v.data))) bad++;
            if (req_ack != '0) begin
                ack_cyc = cyc; ackv = req_ack; errv = req_err; rsp = rsp_data;
                break;
            end
        end
        req_stb[v.idx] = 1'b0;
        check($sformatf("v%0d ack_cycle", vi), ack_cyc, v.ack_cyc);
        check($sformatf("v%0d ack_vec", vi), ackv, oh);
        check($sformatf("v%0d err_vec", vi), errv, v.err ? oh : 4'b0000);
        check($sformatf("v%0d xram_stb_cycle", vi), xfirst, 1);
        check($sformatf("v%0d mem_stb_first", vi), mfirst, v.mstb_first);
        check($sformatf("v%0d mem_stb_count", vi), mcnt, v.mstb_cnt);
        check($sformatf("v%0d rsp_data", vi), rsp, v.rsp);
        check($sformatf("v%0d latch_stable", vi), bad, 0);
        @(negedge clk);
        check($sformatf("v%0d idle_after", vi), busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last_t, found, mcnt, acks;
        logic [3:0] ackv, errv;
        int rr_exp[4];

        rst = 1'b0;
        req_stb = '0; req_wr = '0; req_addr = '0; req_data = '0;
        pt_rd_en = 1'b0; pt_wr_en = 1'b0;
        mem_never = 1'b0; mem_delay = 0; mem_rdata = '0;
        rr_exp = '{0, 1, 3, 0};

        //          idx wr    addr      data   rd    wr    dly mdata  err  ack mst mcnt rsp
        vecs[0] = '{0, 1'b0, 16'h0100, 8'h00, 1'b1, 1'b0, 0, 8'h5A, 1'b0, 3, 2, 1, 8'h5A};
        vecs[1] = '{2, 1'b1, 16'h8000, 8'h11, 1'b1, 1'b0, 0, 8'h00, 1'b1, 2, 0, 0, 8'h5A};
        vecs[2] = '{1, 1'b1, 16'h2000, 8'hC3, 1'b0, 1'b1, 5, 8'h00, 1'b0, 8, 2, 6, 8'h5A};
        vecs[3] = '{3, 1'b0, 16'hFF80, 8'h00, 1'b0, 1'b1, 0, 8'hEE, 1'b1, 2, 0, 0, 8'h00};
        vecs[4] = '{3, 1'b0, 16'h1234, 8'h00, 1'b1, 1'b0, 2, 8'hA5, 1'b0, 5, 2, 3, 8'hA5};
        vecs[5] = '{0, 1'b1, 16'hFFC5, 8'h6B, 1'b0, 1'b1, 0, 8'h00, 1'b0, 3, 2, 1, 8'hA5};
        vecs[6] = '{2, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1, 8'h3C, 1'b0, 4, 2, 2, 8'h3C};

        repeat (2) @(negedge clk);
        check("reset req_ack", req_ack, 0);
        check("reset req_err", req_err, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset busy", busy, 0);
        check("reset xram_addr", xram_addr, 0);
        check("reset xram_wr", xram_wr, 0);
        check("reset xram_data_out", xram_data_out, 0);
        check("reset accesser", accesser, 0);
        check("reset xram_stb", xram_stb, 0);
        check("reset mem_stb", mem_stb, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Master 1 drops its request right after grant; it must still be acked.
        pt_rd_en = 1'b1; pt_wr_en = 1'b0; mem_delay = 0; mem_rdata = 8'h42;
        req_wr[1] = 1'b0; req_addr[31:16] = 16'h0ABC; req_stb[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_stb[1] = 1'b0;
        wait_ack(10, n, ackv, errv);
        check("early_drop ack", ackv, 4'b0010);
        check("early_drop err", errv, 4'b0000);
        check("early_drop cycle", n, 2);
        check("early_drop rsp", rsp_data, 8'h42);
        @(negedge clk);

        // Round robin from a fresh reset: 0,1,3,0 at one transaction per 4 cycles.
        do_reset();
        mem_rdata = 8'h77; req_wr = '0;
        req_addr[15:0] = 16'h1000; req_addr[31:16] = 16'h1100; req_addr[63:48] = 16'h1300;
        req_stb = 4'b1011;
        last_t = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(12, n, ackv, errv);
            check($sformatf("rr%0d grant", k), ackv, 4'b0001 << rr_exp[k]);
            check($sformatf("rr%0d accesser", k), accesser, 3'(rr_exp[k]));
            if (k > 0) check($sformatf("rr%0d spacing", k), cyc_ctr - last_t, 4);
            last_t = cyc_ctr;
        end
        req_stb = '0;
        @(negedge clk);
        check("rr idle", busy, 1'b0);

        // Reset while master 1 sits in ACCESS; pointer must restart at 0.
        req_addr[31:16] = 16'h4444; mem_never = 1'b1; req_stb = 4'b0010;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_stb) begin found = 1; break; end
        end
        check("rst_access reached", found, 1);
        req_addr[15:0] = 16'h0A0A; req_addr[47:32] = 16'h2222;
        req_stb = 4'b0101;
        #2 rst = 1'b0;
        #1;
        check("rst_access mem_stb", mem_stb, 0);
        check("rst_access busy", busy, 0);
        check("rst_access accesser", accesser, 0);
        check("rst_access xram_addr", xram_addr, 0);
        check("rst_access req_ack", req_ack, 0);
        check("rst_access rsp_data", rsp_data, 0);
        @(negedge clk);
        rst = 1'b1; mem_never = 1'b0; mem_rdata = 8'h99;
        wait_ack(10, n, ackv, errv);
        check("rst_access regrant0", ackv, 4'b0001);
        check("rst_access addr0", xram_addr, 16'h0A0A);
        check("rst_access rsp0", rsp_data, 8'h99);
        req_stb[0] = 1'b0;
        wait_ack(10, n, ackv, errv);
        check("rst_access regrant2", ackv, 4'b0100);
        req_stb[2] = 1'b0;
        @(negedge clk);

        // Memory never answers.
        req_addr[63:48] = 16'h3333; mem_never = 1'b1; req_stb = 4'b1000;
        @(posedge clk);
`ifdef OC8051_ARB_TIMEOUT_EN
        mcnt = 0; ackv = '0; errv = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_stb) mcnt++;
            if (req_ack != '0) begin ackv = req_ack; errv = req_err; break; end
        end
        check("timeout mem_stb_count", mcnt, 8);
        check("timeout ack", ackv, 4'b1000);
        check("timeout err", errv, 4'b1000);
        req_stb = '0;
        @(negedge clk);
        mem_never = 1'b0;
`else
        acks = 0;
        repeat (40) begin
            @(negedge clk);
            if (req_ack != '0) acks++;
        end
        check("hang no_ack", acks, 0);
        check("hang busy", busy, 1'b1);
        check("hang mem_stb", mem_stb, 1'b1);
        do_reset();
        mem_never = 1'b0;
`endif

        check("xram_addr stable while busy", addr_glitch, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
